// File: rtl/issue_queue_int_collapse_pkg.sv
// Shared definitions for the issue queue family: default tag/opcode/immediate
// widths, per-entry control flags and payload field offsets.
package iq_pkg;

  localparam int unsigned PREG_W_DEF = 7;
  localparam int unsigned OPC_W_DEF  = 8;
  localparam int unsigned IMM_W_DEF  = 26;

  typedef struct packed {
    logic v;
    logic s1r;
    logic s2r;
  } iq_ctl_t;

  // Payload layout, LSB first: Imm, ImmValid, Opc, RdTag, RdValid, Src1Tag, Src2Tag
  function automatic int unsigned iq_pay_w(input int unsigned preg_w,
                                           input int unsigned opc_w,
                                           input int unsigned imm_w);
    return 3 * preg_w + opc_w + imm_w + 2;
  endfunction

  function automatic int unsigned iq_off_s1t(input int unsigned preg_w,
                                             input int unsigned opc_w,
                                             input int unsigned imm_w);
    return imm_w + 1 + opc_w + preg_w + 1;
  endfunction

  function automatic int unsigned iq_off_s2t(input int unsigned preg_w,
                                             input int unsigned opc_w,
                                             input int unsigned imm_w);
    return imm_w + 1 + opc_w + preg_w + 1 + preg_w;
  endfunction

endpackage

// File: rtl/issue_queue_int_collapse_select.sv
// Oldest-first multi-port picker: port p grants the p-th lowest set bit of
// the ready vector.
module iq_oldest_select #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ISS_W = 2,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]            ready_i,
  output logic [ISS_W-1:0][DEPTH-1:0] gnt_o,
  output logic [ISS_W-1:0][IDX_W-1:0] idx_o,
  output logic [ISS_W-1:0]            vld_o
);

  logic [DEPTH-1:0] rem;
  logic             found;

  always_comb begin
    rem   = ready_i;
    gnt_o = '0;
    idx_o = '0;
    vld_o = '0;
    found = 1'b0;
    for (int unsigned p = 0; p < ISS_W; p++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (rem[i] && !found) begin
          gnt_o[p][i] = 1'b1;
          idx_o[p]    = IDX_W'(i);
          found       = 1'b1;
        end
      end
      vld_o[p] = found;
      rem      = rem & ~gnt_o[p];
    end
  end

endmodule

// File: rtl/issue_queue_int_collapse.sv
// Collapsing integer issue queue: slot index equals age, survivors are
// compacted every cycle and new micro-ops are appended behind them.
module issue_queue_int_collapse
  import iq_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ENQ_W  = 4,
  parameter int unsigned ISS_W  = 2,
  parameter int unsigned WAKE_W = 8,
  parameter int unsigned PREG_W = PREG_W_DEF,
  parameter int unsigned OPC_W  = OPC_W_DEF,
  parameter int unsigned IMM_W  = IMM_W_DEF,
  localparam int unsigned PAY_W = iq_pay_w(PREG_W, OPC_W, IMM_W),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      Clk,
  input  logic                      Rest,
  input  logic                      IsQuIntStop,
  input  logic                      IsQuIntFlash,
  output logic                      IsQuIntReq,
  input  logic [ENQ_W-1:0]          EnqValid,
  input  logic [ENQ_W-1:0]          EnqSrc1Rdy,
  input  logic [ENQ_W-1:0]          EnqSrc2Rdy,
  input  logic [ENQ_W-1:0]          EnqRdValid,
  input  logic [ENQ_W-1:0]          EnqImmValid,
  input  logic [ENQ_W*PREG_W-1:0]   EnqSrc1Tag,
  input  logic [ENQ_W*PREG_W-1:0]   EnqSrc2Tag,
  input  logic [ENQ_W*PREG_W-1:0]   EnqRdTag,
  input  logic [ENQ_W*OPC_W-1:0]    EnqOpc,
  input  logic [ENQ_W*IMM_W-1:0]    EnqImm,
  input  logic [WAKE_W-1:0]         WakeValid,
  input  logic [WAKE_W*PREG_W-1:0]  WakeTag,
  output logic [ISS_W-1:0]          IssValid,
  input  logic [ISS_W-1:0]          IssAccept,
  output logic [ISS_W*PAY_W-1:0]    IssPayload,
  output logic [CNT_W-1:0]          Count
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned OFF_S1T = iq_off_s1t(PREG_W, OPC_W, IMM_W);
  localparam int unsigned OFF_S2T = iq_off_s2t(PREG_W, OPC_W, IMM_W);
  localparam logic [CNT_W-1:0] REQ_TH = CNT_W'(DEPTH - ENQ_W);

  iq_ctl_t [DEPTH-1:0]             ctl_q, ctl_d;
  logic    [DEPTH-1:0][PAY_W-1:0]  pay_q, pay_d;
  logic    [CNT_W-1:0]             cnt_q, cnt_d;

  logic    [DEPTH-1:0]             ready;
  logic    [DEPTH-1:0]             retire;
  logic    [ISS_W-1:0][DEPTH-1:0]  gnt;
  logic    [ISS_W-1:0][IDX_W-1:0]  sel_idx;
  logic    [ISS_W-1:0]             sel_vld;

  int unsigned     nret, nsurv, nacc, pos;
  logic            lane_on;
  logic [IDX_W-1:0] dst;

  function automatic logic woken(input logic [PREG_W-1:0]        tag,
                                 input logic [WAKE_W-1:0]        wv,
                                 input logic [WAKE_W*PREG_W-1:0] wt);
    logic hit;
    hit = 1'b0;
    for (int unsigned w = 0; w < WAKE_W; w++) begin
      hit = hit | (wv[w] && (wt[w*PREG_W +: PREG_W] == tag));
    end
    return hit;
  endfunction

  assign Count      = cnt_q;
  assign IsQuIntReq = (cnt_q > REQ_TH);
  assign IssValid   = sel_vld;

  always_comb begin
    ready = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready[i] = ctl_q[i].v & ctl_q[i].s1r & ctl_q[i].s2r & ~IsQuIntStop;
    end
  end

  iq_oldest_select #(
    .DEPTH (DEPTH),
    .ISS_W (ISS_W),
    .IDX_W (IDX_W)
  ) u_sel (
    .ready_i (ready),
    .gnt_o   (gnt),
    .idx_o   (sel_idx),
    .vld_o   (sel_vld)
  );

  always_comb begin
    IssPayload = '0;
    for (int unsigned p = 0; p < ISS_W; p++) begin
      if (sel_vld[p]) IssPayload[p*PAY_W +: PAY_W] = pay_q[sel_idx[p]];
    end
  end

  always_comb begin
    retire = '0;
    for (int unsigned p = 0; p < ISS_W; p++) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        retire[i] = retire[i] | (gnt[p][i] & IssAccept[p]);
      end
    end
  end

  always_comb begin
    ctl_d   = '0;
    pay_d   = pay_q;
    nret    = 0;
    nsurv   = 0;
    nacc    = 0;
    pos     = 0;
    dst     = '0;
    lane_on = ~IsQuIntReq & ~IsQuIntStop & ~IsQuIntFlash;

    // Each survivor slides down by the number of retired entries below it.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ctl_q[i].v && !retire[i]) begin
        dst        = IDX_W'(i - nret);
        ctl_d[dst] = ctl_q[i];
        pay_d[dst] = pay_q[i];
        nsurv      = nsurv + 1;
      end
      if (retire[i]) nret = nret + 1;
    end

    for (int unsigned k = 0; k < ENQ_W; k++) begin
      lane_on = lane_on & EnqValid[k];
      pos     = nsurv + nacc;
      if (lane_on && pos < DEPTH) begin
        dst            = IDX_W'(pos);
        ctl_d[dst].v   = 1'b1;
        ctl_d[dst].s1r = EnqSrc1Rdy[k];
        ctl_d[dst].s2r = EnqSrc2Rdy[k];
        pay_d[dst]     = {EnqSrc2Tag[k*PREG_W +: PREG_W],
                          EnqSrc1Tag[k*PREG_W +: PREG_W],
                          EnqRdValid[k],
                          EnqRdTag[k*PREG_W +: PREG_W],
                          EnqOpc[k*OPC_W +: OPC_W],
                          EnqImmValid[k],
                          EnqImm[k*IMM_W +: IMM_W]};
        nacc           = nacc + 1;
      end
    end

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ctl_d[i].v) begin
        ctl_d[i].s1r = ctl_d[i].s1r | woken(pay_d[i][OFF_S1T +: PREG_W], WakeValid, WakeTag);
        ctl_d[i].s2r = ctl_d[i].s2r | woken(pay_d[i][OFF_S2T +: PREG_W], WakeValid, WakeTag);
      end
    end

    cnt_d = CNT_W'(nsurv + nacc);
    if (IsQuIntFlash) begin
      ctl_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      ctl_q <= '0;
      cnt_q <= '0;
    end else begin
      ctl_q <= ctl_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload is qualified by V everywhere, so it needs no reset.
  always_ff @(posedge Clk) begin
    pay_q <= pay_d;
  end

endmodule

// File: doc/issue_queue_int_collapse.md
# issue_queue_int_collapse

Parametrised integer issue queue with a collapsing entry array, the successor to the fixed 4-wide integer issue queue. It sits between rename/dispatch and the integer execution ports. Each cycle it accepts up to ENQ_W renamed micro-ops, applies WAKE_W wakeup broadcasts to pending sources, and selects up to ISS_W ready entries oldest-first. Issued entries are removed and the survivors compacted so that age order always equals slot index.

## Interface
- DEPTH, 16: entry count (≥ ENQ_W+ISS_W).
- ENQ_W, 4: dispatch lanes per cycle.
- ISS_W, 2: issue ports.
- WAKE_W, 8: wakeup broadcast ports.
- PREG_W, 7: physical register tag width.
- OPC_W, 8: micro-opcode width.
- IMM_W, 26: immediate width.
- Clk  in  1  sole clock, rising edge.
- Rest  in  1  asynchronous, active-high reset.
- IsQuIntStop  in  1  pipeline stall.
- IsQuIntFlash  in  1  synchronous flush.
- IsQuIntReq  out  1  back-pressure request to the front end.
- EnqValid  in  ENQ_W  per-lane valid; lane k is packed at bit k.
- EnqSrc1Rdy, EnqSrc2Rdy, EnqRdValid, EnqImmValid  in  ENQ_W each  per-lane flags.
- EnqSrc1Tag, EnqSrc2Tag, EnqRdTag  in  ENQ_W*PREG_W each  per-lane tags.
- EnqOpc  in  ENQ_W*OPC_W  per-lane micro-opcodes.
- EnqImm  in  ENQ_W*IMM_W  per-lane immediates.
- WakeValid  in  WAKE_W  wakeup valids.
- WakeTag  in  WAKE_W*PREG_W  wakeup tags.
- IssValid  out  ISS_W  port p holds a selected entry.
- IssAccept  in  ISS_W  the functional unit takes port p this cycle.
- IssPayload  out  ISS_W*(3*PREG_W+OPC_W+IMM_W+2)  per port, packed as {Src2Tag, Src1Tag, RdValid, RdTag, Opc, ImmValid, Imm}.
- Count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry state: V, S1R, S1T, S2R, S2T, RdV, RdT, Opc, ImmV, Imm. Slot 0 is the oldest entry.
- Ready condition: V & S1R & S2R.
- Select: port p gets the p-th lowest-index ready entry. A port with no candidate drives IssValid[p]=0. Select reads registered state only.
- Retire: an entry is removed only if it was selected on port p and IssAccept[p]=1. When IssValid[p]=0, IssAccept[p] is ignored.
- Wakeup: a wakeup port matches a source when WakeValid & WakeTag==SxT. A match sets SxR. Wakeup applies to every resident entry and to incoming enqueue lanes in the same cycle.
- Lane contiguity: enqueue lanes are taken only as a contiguous prefix. Lanes at and above the first EnqValid=0 are ignored.
- Enqueue accept rule: a cycle's enqueue is accepted only if IsQuIntReq=0 and IsQuIntStop=0. Otherwise every lane is dropped, and upstream must hold its data.
- Next-state construction: (1) take survivors, i.e. valid entries not retired; (2) compact them down in original order; (3) append accepted lanes in lane order directly after the last survivor; (4) apply wakeups.
- IsQuIntReq = (Count > DEPTH−ENQ_W). It uses registered Count only; same-cycle retires are not credited.
- Stop: while IsQuIntStop=1, IssValid is forced to 0 and enqueue is blocked. Wakeups still apply.
- Flash: IsQuIntFlash=1 clears every V and Count at the next edge. It overrides enqueue, retire and wakeup in that cycle.
- Rest: asynchronously clears V and Count. Reset values: IssValid=0, IsQuIntReq=0, Count=0, IssPayload=0.

## Timing
- Enqueue to issue: an entry enqueued at edge t (ready at entry, or woken in the same cycle) can drive IssValid in the cycle after edge t, i.e. 1-cycle minimum.
- Wakeup to issue: a wakeup presented in cycle c sets the ready bit at edge c+1. The entry can issue in cycle c+1.
- IssValid/IssPayload are combinational from state. Dependence on IssAccept is forbidden, to avoid a loop.
- Full: Count=DEPTH gives IsQuIntReq=1. Retires still drain the queue. Enqueue resumes once Count ≤ DEPTH−ENQ_W.
- Empty: all IssValid=0. The same-cycle enqueue appears at slot 0 onward.
- A Rest deassertion mid-stream leaves the queue empty. The first edge after deassertion may enqueue.

## Structure
- Shared package iq_pkg holds the entry struct/field offsets, the payload width function, and the default PREG_W/OPC_W/IMM_W constants (common with the future mem and branch queues).
- One sub-module, iq_oldest_select: a DEPTH-bit ready vector goes in, and ISS_W one-hot grants plus an index per port come out, as a priority chain.
- Compaction is done in the top module via prefix-count of survivors (shift amount = number of retired entries below each slot).

## Test plan
- Reset/idle: assert Rest mid-stream with 5 valid entries → IssValid=0, Count=0, IsQuIntReq=0 immediately. After release, enqueue 4 ready ops → Count=4, and next cycle IssValid=2'b11 on slots 0,1.
- Oldest-first with compaction: 6 entries, slots 1,3,4 ready, IssAccept=2'b11 → ports show slots 1,3. The next cycle has Count=4, the old slot 4 now at slot 2, and order preserved.
- Wakeup/enqueue bypass: lane 0 with S1T=0x12 not ready, WakeValid[5]=1 with WakeTag=0x12 in the same cycle → entry issues the following cycle.
- Back-pressure: fill to Count=13 (DEPTH=16) → IsQuIntReq=1. Present 4 lanes → nothing written. Retire 1 → Count=12, Req=0, and the next enqueue is accepted.
- Partial accept: both ports valid, IssAccept=2'b10 → only the port-1 entry is removed, and the port-0 entry is re-selected next cycle.
- Flash vs enqueue: IsQuIntFlash=1 together with 4 valid lanes and 2 accepts → next cycle Count=0 and IssValid=0.
